dec138_rr_arbiter: RTL

Round-robin arbiter that shares one 74LS138 3-to-8 decoder among eight requesters. It drives the decoder's select inputs A/B/C and enables G/G2A/G2B. Each grant appears as exactly one active-low decoder output Y[i]. Select lines change only while the decoder is disabled, so a real TTL part never glitches another output. Sits between the requester logic and the `D_74LS138` instance, replacing the tie-offs (Power on G, Ground on G2A/G2B) used in static decoder circuits.

---
 rtl/dec138_arb_pkg.sv | 27 ++
 rtl/rr_pick8.sv | 29 ++
 rtl/dec138_rr_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dec138_arb_pkg.sv
// Shared types and constants for the round-robin 74LS138 decoder arbiter.
// The enable constants name the electrical levels seen by the TTL part.
package dec138_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_GRANT = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  localparam logic G_ON     = 1'b1;
  localparam logic G2_ON_N  = 1'b0;
  localparam logic G_OFF    = 1'b0;
  localparam logic G2_OFF_N = 1'b1;

  localparam logic [2:0] PTR_RST = 3'd0;
  localparam logic [2:0] SEL_RST = 3'b000;

  localparam int unsigned GAP_W = 4;

  // Round-robin successor of a served index; 3-bit arithmetic wraps 7 to 0.
  function automatic logic [2:0] ptr_after(input logic [2:0] served);
    return served + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// searching upward and wrapping from 7 back to 0.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       found,
  output logic [2:0] idx
);

  logic [15:0] w_dbl;
  logic [7:0]  w_rot;

  // Rotating right by ptr puts the highest-priority requester at bit 0.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[7:0];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    found = 1'b0;
    idx   = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot[k]) begin
        found = 1'b1;
        idx   = ptr + 3'(k);
      end
    end
  end

endmodule

// File: rtl/dec138_rr_arbiter.sv
// Round-robin arbiter driving a shared 74LS138: selects settle for one disabled
// cycle before the decoder is enabled, so no other Y output ever glitches.
module dec138_rr_arbiter
  import dec138_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX   = 15,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       arb_en,
  input  logic [7:0] req,
  output logic       sel_a,
  output logic       sel_b,
  output logic       sel_c,
  output logic       en_g,
  output logic       en_g2a_n,
  output logic       en_g2b_n,
  output logic       grant_valid,
  output logic [2:0] grant_id
);

  localparam int unsigned HOLD_W       = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam bit          HOLD_LIMITED = (HOLD_MAX != 0);
  localparam int unsigned HOLD_LAST_I  = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
  localparam int unsigned GAP_LAST_I   = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
  localparam bit          USE_GAP      = (GAP_CYCLES != 0);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LAST_I);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LAST_I);

  arb_state_t        r_state;
  logic [2:0]        r_ptr;
  logic [2:0]        r_sel;
  logic              r_en_g;
  logic              r_en_g2a_n;
  logic              r_en_g2b_n;
  logic              r_grant_valid;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic       w_found;
  logic [2:0] w_idx;
  logic       w_req_cur;
  logic       w_hold_done;
  logic       w_release;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_req_cur   = req[r_sel];
  assign w_hold_done = HOLD_LIMITED && (r_hold_cnt == HOLD_LAST);
  assign w_release   = !w_req_cur || !arb_en || w_hold_done;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= PTR_RST;
      r_sel         <= SEL_RST;
      r_en_g        <= G_OFF;
      r_en_g2a_n    <= G2_OFF_N;
      r_en_g2b_n    <= G2_OFF_N;
      r_grant_valid <= 1'b0;
      r_hold_cnt    <= '0;
      r_gap_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, independent of statement order.
      case (r_state)
        ST_IDLE: begin
          if (arb_en && w_found) begin
            r_sel   <= w_idx;
            r_state <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (arb_en && w_req_cur) begin
            r_state       <= ST_GRANT;
            r_en_g        <= G_ON;
            r_en_g2a_n    <= G2_ON_N;
            r_en_g2b_n    <= G2_ON_N;
            r_grant_valid <= 1'b1;
            r_hold_cnt    <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_GRANT: begin
          if (w_release) begin
            r_en_g        <= G_OFF;
            r_en_g2a_n    <= G2_OFF_N;
            r_en_g2b_n    <= G2_OFF_N;
            r_grant_valid <= 1'b0;
            r_ptr         <= ptr_after(r_sel);
            r_gap_cnt     <= '0;
            r_state       <= USE_GAP ? ST_GAP : ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end

        ST_GAP: begin
          if (!arb_en || (r_gap_cnt == GAP_LAST)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // grant_id and the select lines share one register: they always agree.
  assign sel_a       = r_sel[0];
  assign sel_b       = r_sel[1];
  assign sel_c       = r_sel[2];
  assign grant_id    = r_sel;
  assign en_g        = r_en_g;
  assign en_g2a_n    = r_en_g2a_n;
  assign en_g2b_n    = r_en_g2b_n;
  assign grant_valid = r_grant_valid;

endmodule
